// File: rtl/mem_rd_arb.sv
// ============================================================================
// mem_rd_arb -- two-port read arbiter onto a single AXI-style read channel
// ----------------------------------------------------------------------------
// Arbitrates between an instruction-fetch (IF) requester and a load/store (LS)
// requester and runs one read at a time on the shared AR/R channels:
//     IDLE -> ADDR -> DATA -> RESP -> IDLE
// The winner and its address are latched in IDLE; the owner's rvalid pulses
// for exactly one cycle in RESP carrying the data of the RLAST beat.
//
// Build option (macro): ARB_RR_EN
//     undefined : fixed priority, LS beats IF on a tie
//     defined   : round-robin, a tie goes to the port not granted last;
//                 the last-grant register resets to IF so LS wins the first tie
//
// Ports
//     ACLK, ARESETn          clock (rising edge), async active-low reset
//     if_req, if_addr        IF read request, address sampled at grant
//     if_rvalid, if_rdata    IF response (one-cycle pulse, data held after)
//     ls_req, ls_addr        LS read request, address sampled at grant
//     ls_rvalid, ls_rdata    LS response (one-cycle pulse, data held after)
//     ARVALID/ARREADY/ARADDR/ARPROT   shared read-address channel
//     RVALID/RREADY/RLAST/RDATA       shared read-data channel
//     busy                   high whenever the FSM is outside IDLE
//
// All outputs come straight from flops. Output flops are loaded from the
// next-state value so they line up with the state they describe.
// ============================================================================
module mem_rd_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              if_req,
    input  logic [63:0]       if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic [63:0]       ls_addr,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [2:0]        ARPROT,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic              RLAST,
    input  logic [DATA_W-1:0] RDATA,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Owner encoding: IF = 0 so the reset value of the owner register is IF.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam logic [2:0] PROT_IF = 3'b100;  // instruction access
    localparam logic [2:0] PROT_LS = 3'b000;  // data access

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          prot_q, prot_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                busy_q, busy_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

    logic                any_req_s;
    logic                grant_ls_s;
    logic                ar_hs_s;
    logic                r_last_s;
    logic                unused_addr_s;

`ifdef ARB_RR_EN
    logic                last_q, last_d;
`endif

    // Only the low ADDR_W bits of each 64-bit request address reach ARADDR.
    assign unused_addr_s = ^{if_addr, ls_addr};

    assign ar_hs_s  = arvalid_q && ARREADY;
    assign r_last_s = rready_q && RVALID && RLAST;

    // Arbitration: pick the winner among the currently raised requests.
    always_comb begin
        any_req_s  = if_req || ls_req;
        grant_ls_s = 1'b0;
`ifdef ARB_RR_EN
        if (if_req && ls_req) begin
            // Tie: the port that did not win the previous grant goes first.
            grant_ls_s = (last_q == OWN_IF);
        end else begin
            grant_ls_s = ls_req;
        end
`else
        if (ls_req) begin
            grant_ls_s = 1'b1;
        end else begin
            grant_ls_s = 1'b0;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (ar_hs_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                // Non-last beats are accepted and simply dropped.
                if (r_last_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transaction context: owner, address, protection and captured data.
    always_comb begin
        owner_d = owner_q;
        addr_d  = addr_q;
        prot_d  = prot_q;
        data_d  = data_q;
`ifdef ARB_RR_EN
        last_d  = last_q;
`endif
        if ((state_q == ST_IDLE) && any_req_s) begin
            // Request lines are only looked at here, so later changes to
            // req/addr cannot disturb the transaction in flight.
            owner_d = grant_ls_s;
            if (grant_ls_s) begin
                addr_d = ls_addr[ADDR_W-1:0];
                prot_d = PROT_LS;
            end else begin
                addr_d = if_addr[ADDR_W-1:0];
                prot_d = PROT_IF;
            end
`ifdef ARB_RR_EN
            last_d = grant_ls_s;
`endif
        end else if ((state_q == ST_DATA) && r_last_s) begin
            data_d = RDATA;
        end else begin
            data_d = data_q;
        end
    end

    // FSM output logic: next values for every output flop, keyed on state_d.
    always_comb begin
        arvalid_d   = (state_d == ST_ADDR);
        rready_d    = (state_d == ST_DATA);
        busy_d      = (state_d != ST_IDLE);
        if_rvalid_d = (state_d == ST_RESP) && (owner_d == OWN_IF);
        ls_rvalid_d = (state_d == ST_RESP) && (owner_d == OWN_LS);
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if (if_rvalid_d) begin
            if_rdata_d = data_d;
        end else begin
            if_rdata_d = if_rdata_q;
        end
        if (ls_rvalid_d) begin
            ls_rdata_d = data_d;
        end else begin
            ls_rdata_d = ls_rdata_q;
        end
    end

    // Context and output registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            owner_q     <= OWN_IF;
            addr_q      <= {ADDR_W{1'b0}};
            prot_q      <= 3'b000;
            data_q      <= {DATA_W{1'b0}};
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            ls_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            prot_q      <= prot_d;
            data_q      <= data_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            busy_q      <= busy_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

`ifdef ARB_RR_EN
    // Last-grant register for round-robin; resets to IF.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign ARVALID   = arvalid_q;
    assign ARADDR    = addr_q;
    assign ARPROT    = prot_q;
    assign RREADY    = rready_q;
    assign busy      = busy_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_rd_arb.sv
// ============================================================================
// tb_mem_rd_arb -- self-checking bench for mem_rd_arb
// The driver plays both requesters and the memory slave cycle by cycle. For
// each grant the expected response (owner, last-beat data, arrival cycle) is
// pushed to a scoreboard; an independent monitor pops it when an rvalid
// pulse appears. Compile with +define+ARB_RR_EN to check round-robin.
// ============================================================================
module tb_mem_rd_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b1;
    logic              if_req = 1'b0;
    logic [63:0]       if_addr = 64'd0;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req = 1'b0;
    logic [63:0]       ls_addr = 64'd0;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ARVALID;
    logic              ARREADY = 1'b0;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic              RVALID = 1'b0;
    logic              RREADY;
    logic              RLAST = 1'b0;
    logic [DATA_W-1:0] RDATA = 64'd0;
    logic              busy;

    mem_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RDATA(RDATA),
        .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    typedef struct {
        bit          owner;   // 0 = IF, 1 = LS
        logic [63:0] data;
        int          at_cyc;  // cycle count at which the pulse must be visible
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] hold_if = 64'd0;
    logic [63:0] hold_ls = 64'd0;
    bit          model_last = 1'b0;   // last granted port, 0 = IF
    logic [63:0] beats[8];
    logic [2:0]  got_prot;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Arbitration rule: tie -> LS (fixed) or the port not granted last (RR).
    function automatic bit pick(input bit ir, input bit lr);
        if (ir && lr) return RR ? !model_last : 1'b1;
        return lr;
    endfunction

    // Monitor: pops one expectation per rvalid pulse, checks held data otherwise.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (if_rvalid || ls_rvalid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_rvalid: got if=%0b ls=%0b, want no pulse (cycle %0d)",
                             if_rvalid, ls_rvalid, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("rvalid_owner", 64'({if_rvalid, ls_rvalid}),
                          mon_e.owner ? 64'd1 : 64'd2);
                    check("rdata", mon_e.owner ? ls_rdata : if_rdata, mon_e.data);
                    check("latency", 64'(cyc), 64'(mon_e.at_cyc));
                    if (mon_e.owner) hold_ls = mon_e.data;
                    else             hold_if = mon_e.data;
                end
            end
            if (!if_rvalid) check("if_rdata_hold", if_rdata, hold_if);
            if (!ls_rvalid) check("ls_rdata_hold", ls_rdata, hold_ls);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    64'(busy), 64'd0);
        check({tag, "_arvalid"}, 64'(ARVALID), 64'd0);
        check({tag, "_araddr"},  64'(ARADDR), 64'd0);
        check({tag, "_arprot"},  64'(ARPROT), 64'd0);
        check({tag, "_rready"},  64'(RREADY), 64'd0);
        check({tag, "_if_rv"},   64'(if_rvalid), 64'd0);
        check({tag, "_ls_rv"},   64'(ls_rvalid), 64'd0);
        check({tag, "_if_rd"},   if_rdata, 64'd0);
        check({tag, "_ls_rd"},   ls_rdata, 64'd0);
    endtask

    // One complete read. Request sampled at edge S; ARREADY low for ar_wait
    // ADDR cycles; nb beats back to back; pulse visible after edge S+ar_wait+1+nb.
    task automatic run_txn(input bit ir, input bit lr, input logic [63:0] ia,
                           input logic [63:0] la, input int ar_wait, input int nb,
                           input bit drop, input bit scramble, input bit rst_abort);
        bit         w;
        logic [31:0] ea;
        logic [2:0] ep;
        int         s;
        w  = pick(ir, lr);
        ea = w ? la[31:0] : ia[31:0];
        ep = w ? 3'b000 : 3'b100;
        check("idle_busy", 64'(busy), 64'd0);
        if_req = ir; ls_req = lr; if_addr = ia; ls_addr = la;
        ARREADY = 1'b0;
        step();
        s = cyc;
        model_last = w;
        if (!rst_abort) sb.push_back('{w, beats[nb-1], s + ar_wait + 1 + nb});
        if (drop) begin
            if (w) ls_req = 1'b0;
            else   if_req = 1'b0;
        end
        if (scramble) begin
            if_addr = {$urandom, $urandom};
            ls_addr = {$urandom, $urandom};
            if (w) if_req = 1'($urandom_range(0, 1));
            else   ls_req = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k <= ar_wait; k++) begin
            if (k == ar_wait) ARREADY = 1'b1;
            if (k == 0) got_prot = ARPROT;
            check("arvalid", 64'(ARVALID), 64'd1);
            check("araddr", 64'(ARADDR), 64'(ea));
            check("arprot", 64'(ARPROT), 64'(ep));
            check("rready_in_addr", 64'(RREADY), 64'd0);
            check("busy_in_addr", 64'(busy), 64'd1);
            step();
        end
        ARREADY = 1'b0;
        check("arvalid_after_hs", 64'(ARVALID), 64'd0);
        check("rready_in_data", 64'(RREADY), 64'd1);
        if (rst_abort) begin
            RVALID = 1'b1; RDATA = beats[0]; RLAST = 1'b0;
            step();
            RVALID = 1'b0;
            ARESETn = 1'b0;
            sb.delete();
            hold_if = 64'd0;
            hold_ls = 64'd0;
            model_last = 1'b0;
            if_req = 1'b0; ls_req = 1'b0;
            #1;
            check_all_zero("rst_mid");
            step();
            step();
            ARESETn = 1'b1;
            return;
        end
        for (int b = 0; b < nb; b++) begin
            RVALID = 1'b1; RDATA = beats[b]; RLAST = (b == nb - 1);
            step();
        end
        RVALID = 1'b0; RLAST = 1'b0; RDATA = 64'd0;
        check("rready_in_resp", 64'(RREADY), 64'd0);
        check("busy_in_resp", 64'(busy), 64'd1);
        step();
        check("busy_back_idle", 64'(busy), 64'd0);
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_prot;
        #2 ARESETn = 1'b0;
        step();
        step();
        check_all_zero("reset");
        ARESETn = 1'b1;
        step();

        // Both requesters high for four back-to-back transactions.
        for (int i = 0; i < 4; i++) begin
            beats[0] = {$urandom, $urandom};
            run_txn(1'b1, 1'b1, 64'h0000_0000_1000_0000 + 64'(i),
                    64'h0000_0000_2000_0000 + 64'(i), 0, 1, 1'b0, 1'b0, 1'b0);
            exp_prot = (RR && (i % 2 == 1)) ? 3'b100 : 3'b000;
            check($sformatf("arb_seq_%0d", i), 64'(got_prot), 64'(exp_prot));
        end
        step();

        // Minimum-latency IF read: pulse in the 4th cycle (IDLE, ADDR, DATA, RESP).
        beats[0] = 64'h1122_3344_5566_7788;
        run_txn(1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd0, 0, 1, 1'b0, 1'b0, 1'b0);

        // ARREADY held low for five cycles.
        beats[0] = {$urandom, $urandom};
        run_txn(1'b1, 1'b0, 64'hFFFF_0000_1234_5678, 64'd0, 5, 1, 1'b0, 1'b0, 1'b0);

        // Three-beat burst A,B,C: only C is delivered.
        beats[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        beats[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        beats[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        run_txn(1'b0, 1'b1, 64'd0, 64'h0000_0000_4000_0040, 0, 3, 1'b0, 1'b0, 1'b0);

        // LS drops its request right after grant.
        beats[0] = 64'hDEAD_BEEF_0BAD_F00D;
        run_txn(1'b0, 1'b1, 64'd0, 64'h0000_0000_0000_1000, 1, 1, 1'b1, 1'b0, 1'b0);

        // Reset while in DATA, then a fresh LS read.
        beats[0] = 64'h0101_0101_0101_0101;
        run_txn(1'b0, 1'b1, 64'd0, 64'h0000_0000_0000_2000, 0, 2, 1'b0, 1'b0, 1'b1);
        check_all_zero("post_rst");
        beats[0] = 64'h5A5A_5A5A_A5A5_A5A5;
        run_txn(1'b0, 1'b1, 64'd0, 64'h0000_0000_0000_3000, 0, 1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            bit ir, lr;
            int nb;
            ir = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
            if (!ir && !lr) ir = 1'b1;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) beats[b] = {$urandom, $urandom};
            run_txn(ir, lr, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), nb, ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) step();
        end

        step();
        step();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_rd_arb.md
MEM_RD_ARB -- requirements
Module: mem_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of ARADDR and of each requester address.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the width of RDATA and of each response data bus.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESETn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports if_req (input, 1) and if_addr (input, 64): instruction-fetch read request, with the address sampled at grant.
REQ-006 SHALL have ports if_rvalid (output, 1) and if_rdata (output, DATA_W): instruction-fetch response.
REQ-007 SHALL have ports ls_req (input, 1) and ls_addr (input, 64): load/store-unit read request.
REQ-008 SHALL have ports ls_rvalid (output, 1) and ls_rdata (output, DATA_W): load/store-unit response.
REQ-009 SHALL have ports ARVALID (output, 1), ARREADY (input, 1), ARADDR (output, ADDR_W) and ARPROT (output, 3): the shared read-address channel.
REQ-010 SHALL have ports RVALID (input, 1), RREADY (output, 1), RLAST (input, 1) and RDATA (input, DATA_W): the shared read-data channel.
REQ-011 SHALL have port busy (output, 1), high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement the FSM IDLE -> ADDR -> DATA -> RESP -> IDLE, with state, owner, address and data all held in registers.
REQ-013 In IDLE with at least one request high, SHALL register the winner (owner) and its address[ADDR_W-1:0], then enter ADDR on the next edge.
REQ-014 In ADDR SHALL drive ARVALID=1, ARADDR=latched address and ARPROT=3'b100 for IF or 3'b000 for LS.
REQ-015 SHALL hold ARADDR and ARPROT stable until ARVALID&&ARREADY, then enter DATA; ARVALID SHALL never drop before that handshake.
REQ-016 In DATA SHALL drive RREADY=1.
REQ-017 In DATA, each RVALID beat with RLAST=0 SHALL be accepted and discarded.
REQ-018 In DATA, on RVALID&&RLAST SHALL capture RDATA and enter RESP.
REQ-019 In RESP SHALL pulse the owner's rvalid for exactly one cycle with rdata = captured data, then enter IDLE.
REQ-020 The non-owner's rvalid SHALL remain 0 in every state.
REQ-021 Each rdata output SHALL hold its last delivered value between pulses.
REQ-022 Minimum latency SHALL be 4 cycles from a request sampled in IDLE to the rvalid pulse (ARREADY already high; RVALID&&RLAST on the first DATA cycle).
REQ-023 A requester SHALL hold req and addr until its rvalid pulse.
REQ-024 If a requester drops req after grant, the transaction SHALL still complete and pulse its rvalid.
REQ-025 Request changes outside IDLE SHALL not affect the in-flight owner or address.
REQ-026 ARVALID SHALL be 0 outside ADDR, and RREADY SHALL be 0 outside DATA.
REQ-027 Simultaneous if_req and ls_req SHALL be resolved by the arbitration policy in REQ-031/REQ-032; the loser waits in IDLE for the next arbitration.
REQ-028 Back-to-back grants SHALL pass through IDLE for one cycle, giving at most one outstanding transaction.

Reset
REQ-029 On ARESETn low, SHALL asynchronously force IDLE, and zero owner, captured data, if_rvalid, ls_rvalid, if_rdata, ls_rdata, ARVALID, ARADDR, ARPROT, RREADY and busy.
REQ-030 Reset mid-transaction SHALL abandon it with no rvalid pulse; after release, the first sampled request SHALL start a fresh transaction.

Configuration
REQ-031 With ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, grant the port not granted last (last-grant register resets to IF, so LS wins the first tie).
REQ-032 Without ARB_RR_EN, arbitration SHALL be fixed priority with LS over IF, and no last-grant register SHALL exist.

Verification
REQ-033 Bench SHALL cover: if_req with if_addr=0x80000000, ARREADY=1, single beat RDATA=0x1122334455667788 -> ARADDR=0x80000000, ARPROT=100, if_rvalid pulse 4 cycles after request, if_rdata=0x1122334455667788.
REQ-034 Bench SHALL cover: ARREADY held low 5 cycles -> ARVALID and ARADDR stable all 5 cycles, DATA entered only after the handshake.
REQ-035 Bench SHALL cover: both reqs high continuously for 4 transactions -> LS,LS,LS,LS without ARB_RR_EN; LS,IF,LS,IF with it.
REQ-036 Bench SHALL cover: 3-beat response (RLAST on beat 3, data A,B,C) -> one rvalid pulse, rdata=C.
REQ-037 Bench SHALL cover: ARESETn asserted in DATA -> all outputs 0 immediately, no rvalid pulse; a new ls_req after release completes normally.
REQ-038 Bench SHALL cover: ls_req dropped the cycle after grant -> ls_rvalid still pulses once, and if_rvalid stays 0.
